text_cursor_ctrl: RTL and testbench
===================================

Name: text_cursor_ctrl

Overview:
Write-side controller for the character buffer RAM in the CLK_DATA domain. It accepts a byte stream over a valid/ready handshake and tracks the cursor row and column. Control characters CR, LF, BS and FF are interpreted. The block sequences single-cycle writes and full-screen clear sweeps onto the RAM write port (port B), and latches the display geometry (rows, columns) used for address generation and wrap.

Parameters:
FILL_CHAR, 8'h20, byte written by clear sweeps and backspace erase
DEFAULT_ROWS, 8'd128, max_rows value after reset
DEFAULT_COLS, 8'd160, max_columns value after reset
ADDR_W, 16, RAM address width

Ports:
CLK_DATA  in  1  data-domain clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
data  in  8  input character
data_valid  in  1  data is presented
data_ready  out  1  byte accepted on cycles where data_valid && data_ready
max_rows  in  8  requested row count
max_columns  in  8  requested column count
cfg_update  in  1  one-cycle strobe that latches max_rows/max_columns
clear_req  in  1  one-cycle strobe that requests a screen clear
ram_en  out  1  RAM port enable
ram_we  out  1  RAM write enable; always equal to ram_en
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  8  RAM write data
cur_row  out  8  cursor row
cur_col  out  8  cursor column
busy  out  1  clear sweep in progress

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; ram_en=ram_we=0, ram_addr=0, ram_wdata=0, cur_row=cur_col=0, busy=0. Geometry is set to DEFAULT_ROWS/DEFAULT_COLS. No automatic clear. Reset asserted during a sweep aborts it immediately.
- States: IDLE, CLEAR.
- data_ready = (state==IDLE) && !cfg_update && !clear_req. This is combinational.
- Priority in IDLE: cfg_update > clear_req > data.
- cfg_update: latch max_rows/max_columns; a value of 0 is latched as 1. Then enter CLEAR.
- clear_req, or an accepted byte 8'h0C: enter CLEAR.
- All RAM outputs are registered. ram_en is a 1-cycle pulse per write and is 0 otherwise.
- Address rule: ram_addr = cur_row*cols + cur_col, computed at ADDR_W bits (max 255*255 fits in 16 bits).
- Accepted byte in cycle N, for printable and non-control codes: ram_en/ram_we high in cycle N+1, with the current cursor address and wdata=data.
  - Cursor advances in N+1: col+1.
  - If col==cols-1: col=0 and row advances.
- Row advance: row = (row==rows-1) ? 0 : row+1. Wraps to the top; there is no scrolling.
- 8'h0D and 8'h0A: col=0, row advances, no RAM write.
- 8'h08: col = (col==0) ? 0 : col-1. Then FILL_CHAR is written at the new cursor position in N+1 (at col 0, it overwrites col 0).
- CLEAR: request seen in cycle N.
  - Cycles N+1 .. N+rows*cols present one write per cycle: addr 0,1,...,rows*cols-1, wdata=FILL_CHAR.
  - busy=1 over the same cycles.
  - At N+rows*cols+1: state IDLE, busy=0, cursor (0,0).
  - cfg_update, clear_req and data are ignored while in CLEAR.
- If a cfg_update latch shrinks the geometry below the cursor position, the cursor is reset to (0,0) by the clear.
- cur_row/cur_col are registered and always < rows/cols.

Test Plan:
- Release reset, send 0x41 with valid -> next cycle ram_en=ram_we=1, ram_addr=0, ram_wdata=0x41; cur_col=1; ram_en=0 the cycle after.
- cfg_update with rows=2, cols=4 -> busy=1 for 8 cycles, writes 0x20 to addr 0..7, data_ready=0 throughout; then 5 chars 'a'..'e' -> addrs 0,1,2,3,4; cursor (1,1).
- Geometry 2x4, cursor at (1,3), send 'Z' -> write addr 7, cursor wraps to (0,0); then 0x0D at (0,2) -> no ram_en, cursor (1,0).
- Geometry 2x4, cursor (1,2), send 0x08 -> write 0x20 at addr 5, cursor (1,1); at (0,0), send 0x08 -> write 0x20 at addr 0, cursor stays (0,0).
- Same cycle: cfg_update=1, clear_req=1, data_valid=1 -> data_ready=0, byte not consumed, geometry latched, exactly one sweep of rows*cols writes; cfg with rows=0 -> latched as 1.
- Default geometry, clear_req, then reset=0 at the 3rd sweep write -> next cycle ram_en=0, busy=0, cursor (0,0); after release, data_ready=1 and the geometry is 128x160.

Source files
------------

// File: rtl/text_cursor_ctrl_if.sv
// text_cursor_ctrl_if: byte stream in (data/data_valid/data_ready), geometry and strobes in (max_rows/max_columns/cfg_update/clear_req), RAM port B and cursor/busy status out
interface text_cursor_ctrl_if #(parameter int ADDR_W = 16);
  logic [7:0] data;
  logic data_valid;
  logic data_ready;
  logic [7:0] max_rows;
  logic [7:0] max_columns;
  logic cfg_update;
  logic clear_req;
  logic ram_en;
  logic ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] cur_row;
  logic [7:0] cur_col;
  logic busy;
  modport master (
    output data, data_valid, max_rows, max_columns, cfg_update, clear_req,
    input data_ready, ram_en, ram_we, ram_addr, ram_wdata, cur_row, cur_col, busy
  );
  modport slave (
    input data, data_valid, max_rows, max_columns, cfg_update, clear_req,
    output data_ready, ram_en, ram_we, ram_addr, ram_wdata, cur_row, cur_col, busy
  );
endinterface

// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl: char-buffer write controller; CLK_DATA/reset (sync, active-low) plus bus (byte stream in, geometry/clear strobes in, RAM port B writes and cursor/busy out)
module text_cursor_ctrl #(
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter logic [7:0] DEFAULT_ROWS = 8'd128,
  parameter logic [7:0] DEFAULT_COLS = 8'd160,
  parameter int ADDR_W = 16
) (
  input logic CLK_DATA,
  input logic reset,
  text_cursor_ctrl_if.slave bus
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, nxt_state;
  logic [7:0] rows, cols, row, col, wdata;
  logic [7:0] nxt_rows, nxt_cols, nxt_row, nxt_col, nxt_wdata;
  logic [ADDR_W-1:0] cnt, addr, nxt_cnt, nxt_addr, base, total;
  logic en, busy, nxt_en, nxt_busy;
  logic [7:0] row_adv, col_dec;
  logic last_col, acc, start_clr;
  assign base = ADDR_W'(row) * ADDR_W'(cols);
  assign total = ADDR_W'(rows) * ADDR_W'(cols);
  assign row_adv = row == rows - 8'd1 ? 8'd0 : row + 8'd1;
  assign col_dec = col == 8'd0 ? 8'd0 : col - 8'd1;
  assign last_col = col == cols - 8'd1;
  assign bus.data_ready = state == IDLE && !bus.cfg_update && !bus.clear_req;
  assign acc = bus.data_valid && bus.data_ready;
  assign start_clr = state == IDLE && (bus.cfg_update || bus.clear_req || (acc && bus.data == 8'h0C));
  always_comb begin
    nxt_state = state;
    nxt_rows = rows;
    nxt_cols = cols;
    nxt_row = row;
    nxt_col = col;
    nxt_cnt = cnt;
    nxt_addr = addr;
    nxt_wdata = wdata;
    nxt_en = 1'b0;
    nxt_busy = busy;
    if (start_clr) begin
      nxt_state = CLEAR;
      nxt_en = 1'b1;
      nxt_addr = '0;
      nxt_wdata = FILL_CHAR;
      nxt_busy = 1'b1;
      nxt_cnt = ADDR_W'(1);
      nxt_row = 8'd0;
      nxt_col = 8'd0;
      if (bus.cfg_update) begin
        nxt_rows = bus.max_rows == 8'd0 ? 8'd1 : bus.max_rows;
        nxt_cols = bus.max_columns == 8'd0 ? 8'd1 : bus.max_columns;
      end
    end else if (state == CLEAR) begin
      if (cnt == total) begin
        nxt_state = IDLE;
        nxt_busy = 1'b0;
      end else begin
        nxt_en = 1'b1;
        nxt_addr = cnt;
        nxt_cnt = cnt + ADDR_W'(1);
      end
    end else if (acc) begin
      if (bus.data == 8'h0D || bus.data == 8'h0A) begin
        nxt_row = row_adv;
        nxt_col = 8'd0;
      end else if (bus.data == 8'h08) begin
        nxt_col = col_dec;
        nxt_en = 1'b1;
        nxt_addr = base + ADDR_W'(col_dec);
        nxt_wdata = FILL_CHAR;
      end else begin
        nxt_en = 1'b1;
        nxt_addr = base + ADDR_W'(col);
        nxt_wdata = bus.data;
        nxt_col = last_col ? 8'd0 : col + 8'd1;
        nxt_row = last_col ? row_adv : row;
      end
    end
  end
  always_ff @(posedge CLK_DATA) begin
    if (!reset) begin
      state <= IDLE;
      rows <= DEFAULT_ROWS;
      cols <= DEFAULT_COLS;
      row <= 8'd0;
      col <= 8'd0;
      cnt <= '0;
      addr <= '0;
      wdata <= 8'd0;
      en <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt_state;
      rows <= nxt_rows;
      cols <= nxt_cols;
      row <= nxt_row;
      col <= nxt_col;
      cnt <= nxt_cnt;
      addr <= nxt_addr;
      wdata <= nxt_wdata;
      en <= nxt_en;
      busy <= nxt_busy;
    end
  end
  assign bus.ram_en = en;
  assign bus.ram_we = en;
  assign bus.ram_addr = addr;
  assign bus.ram_wdata = wdata;
  assign bus.cur_row = row;
  assign bus.cur_col = col;
  assign bus.busy = busy;
endmodule

// File: tb/tb_text_cursor_ctrl.sv
// tb_text_cursor_ctrl: directed and random stimulus against a linear-position reference model
module tb_text_cursor_ctrl;
  logic CLK_DATA = 1'b0;
  logic reset = 1'b0;
  always #5 CLK_DATA = ~CLK_DATA;
  text_cursor_ctrl_if bus();
  text_cursor_ctrl dut (.CLK_DATA(CLK_DATA), .reset(reset), .bus(bus));
  int passed = 0;
  int failed = 0;
  int total = 0;
  int m_rows = 128;
  int m_cols = 160;
  int m_row = 0;
  int m_col = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK_DATA);
    #1;
  endtask
  task automatic chk_cursor(input string tag);
    chk({tag, ".row"}, 32'(bus.cur_row), m_row);
    chk({tag, ".col"}, 32'(bus.cur_col), m_col);
  endtask
  task automatic expect_sweep(input string tag);
    int n;
    n = m_rows * m_cols;
    for (int i = 0; i < n; i++) begin
      chk({tag, ".en"}, 32'(bus.ram_en), 1);
      chk({tag, ".we"}, 32'(bus.ram_we), 1);
      chk({tag, ".addr"}, 32'(bus.ram_addr), i);
      chk({tag, ".wdata"}, 32'(bus.ram_wdata), 32'h20);
      chk({tag, ".busy"}, 32'(bus.busy), 1);
      chk({tag, ".ready"}, 32'(bus.data_ready), 0);
      tick();
    end
    m_row = 0;
    m_col = 0;
    chk({tag, ".end_en"}, 32'(bus.ram_en), 0);
    chk({tag, ".end_busy"}, 32'(bus.busy), 0);
    chk({tag, ".end_ready"}, 32'(bus.data_ready), 1);
    chk_cursor({tag, ".end"});
  endtask
  task automatic put(input logic [7:0] b);
    int a;
    int lin;
    logic wr;
    logic [7:0] wd;
    chk("put.ready", 32'(bus.data_ready), 1);
    bus.data = b;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    if (b == 8'h0C) begin
      expect_sweep("ff");
      return;
    end
    wr = 1'b1;
    wd = b;
    a = 0;
    if (b == 8'h0D || b == 8'h0A) begin
      wr = 1'b0;
      m_row = (m_row + 1) % m_rows;
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
      a = m_row * m_cols + m_col;
      wd = 8'h20;
    end else begin
      a = m_row * m_cols + m_col;
      lin = (a + 1) % (m_rows * m_cols);
      m_row = lin / m_cols;
      m_col = lin % m_cols;
    end
    chk("put.en", 32'(bus.ram_en), 32'(wr));
    chk("put.we", 32'(bus.ram_we), 32'(wr));
    if (wr) begin
      chk("put.addr", 32'(bus.ram_addr), a);
      chk("put.wdata", 32'(bus.ram_wdata), 32'(wd));
    end
    chk_cursor("put");
  endtask
  task automatic cfg(input int r, input int c, input logic clr, input logic val, input logic [7:0] b);
    bus.max_rows = 8'(r);
    bus.max_columns = 8'(c);
    bus.cfg_update = 1'b1;
    bus.clear_req = clr;
    bus.data_valid = val;
    bus.data = b;
    #1;
    chk("cfg.ready", 32'(bus.data_ready), 0);
    tick();
    bus.cfg_update = 1'b0;
    bus.clear_req = 1'b0;
    bus.data_valid = 1'b0;
    m_rows = r == 0 ? 1 : r;
    m_cols = c == 0 ? 1 : c;
    expect_sweep("cfg");
  endtask
  initial begin
    int r;
    logic [7:0] b;
    bus.data = 8'd0;
    bus.data_valid = 1'b0;
    bus.max_rows = 8'd0;
    bus.max_columns = 8'd0;
    bus.cfg_update = 1'b0;
    bus.clear_req = 1'b0;
    repeat (3) tick();
    chk("rst.en", 32'(bus.ram_en), 0);
    chk("rst.we", 32'(bus.ram_we), 0);
    chk("rst.addr", 32'(bus.ram_addr), 0);
    chk("rst.wdata", 32'(bus.ram_wdata), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.ready", 32'(bus.data_ready), 1);
    chk_cursor("rst");
    reset = 1'b1;
    tick();
    put(8'h41);
    chk("first.col", 32'(bus.cur_col), 1);
    tick();
    chk("first.en_off", 32'(bus.ram_en), 0);
    cfg(2, 4, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) put(8'h61 + 8'(i));
    chk("ae.row", 32'(bus.cur_row), 1);
    chk("ae.col", 32'(bus.cur_col), 1);
    put(8'h78);
    put(8'h79);
    put(8'h5A);
    chk("wrap.addr", 32'(bus.ram_addr), 7);
    chk("wrap.row", 32'(bus.cur_row), 0);
    chk("wrap.col", 32'(bus.cur_col), 0);
    put(8'h70);
    put(8'h71);
    put(8'h0D);
    chk("cr.row", 32'(bus.cur_row), 1);
    chk("cr.col", 32'(bus.cur_col), 0);
    put(8'h72);
    put(8'h73);
    put(8'h08);
    chk("bs.addr", 32'(bus.ram_addr), 5);
    chk("bs.col", 32'(bus.cur_col), 1);
    put(8'h0C);
    put(8'h08);
    chk("bs0.addr", 32'(bus.ram_addr), 0);
    chk("bs0.col", 32'(bus.cur_col), 0);
    cfg(3, 5, 1'b1, 1'b1, 8'h6B);
    cfg(0, 3, 1'b0, 1'b0, 8'h00);
    repeat (6) begin
      cfg($urandom_range(0, 5), $urandom_range(1, 7), 1'($urandom), 1'($urandom), 8'($urandom));
      repeat (40) begin
        r = $urandom_range(0, 12);
        b = r == 0 ? 8'h0D : r == 1 ? 8'h0A : r <= 3 ? 8'h08 : (r == 4 && $urandom_range(0, 3) == 0) ? 8'h0C : 8'($urandom_range(0, 255));
        if (b == 8'h0C && r != 4) b = 8'h20;
        put(b);
        if ($urandom_range(0, 2) == 0) begin
          tick();
          chk("gap.en", 32'(bus.ram_en), 0);
        end
      end
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_rows = 128;
    m_cols = 160;
    m_row = 0;
    m_col = 0;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    chk("abort.w0", 32'(bus.ram_addr), 0);
    tick();
    chk("abort.w1", 32'(bus.ram_addr), 1);
    tick();
    chk("abort.w2", 32'(bus.ram_addr), 2);
    chk("abort.busy_on", 32'(bus.busy), 1);
    reset = 1'b0;
    tick();
    chk("abort.en", 32'(bus.ram_en), 0);
    chk("abort.busy", 32'(bus.busy), 0);
    chk_cursor("abort");
    reset = 1'b1;
    #1;
    chk("abort.ready", 32'(bus.data_ready), 1);
    put(8'h0D);
    put(8'h41);
    chk("dflt.addr", 32'(bus.ram_addr), 160);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
